adder_err_accum: RTL and testbench
==================================

ADDER_ERR_ACCUM -- requirements
Module: adder_err_accum

Interface
REQ-001 Parameter: NUM_SAMPLES, default 4096; number of accepted samples per run (1..4096).
REQ-002 Parameter: OP_W, default 6; operand width; approximate sum width is OP_W+1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 in_valid  input  1  sample on in_a/in_b/in_approx is valid.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_a  input  OP_W  operand A, as driven to the 6-bit adder under test.
REQ-009 in_b  input  OP_W  operand B, as driven to the 6-bit adder under test.
REQ-010 in_approx  input  OP_W+1  adder-under-test output (po6..po0, po6 = MSB).
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  level; run complete, results stable.
REQ-013 err_count  output  13  samples where in_approx != exact sum.
REQ-014 max_abs_err  output  OP_W+1  largest |in_approx - exact| seen.
REQ-015 sum_abs_err  output  19  sum of |in_approx - exact| over the run.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; encoding is the shared-package enum.
REQ-017 IDLE: in_ready=0, busy=0, done=0; start -> RUN, clears all accumulators and sample counter.
REQ-018 RUN: in_ready=1, busy=1; a sample is accepted on a cycle where in_valid and in_ready are both 1.
REQ-019 Exact sum = zero-extended in_a + in_b, OP_W+1 bits, no truncation.
REQ-020 Absolute error = |in_approx - exact| computed at OP_W+2 signed width, result fits OP_W+1 bits.
REQ-021 Each accepted sample is registered into one pipeline stage; accumulators update on the following edge (latency 1 cycle).
REQ-022 err_count increments by 1 when abs error != 0; max_abs_err takes abs error if larger; sum_abs_err adds abs error.
REQ-023 Sample counter increments per accept; on the accept that brings it to NUM_SAMPLES, in_ready drops next cycle and FSM -> DRAIN.
REQ-024 DRAIN: in_ready=0, busy=1; lasts exactly one cycle while the final sample updates accumulators, then -> DONE.
REQ-025 DONE: done=1, busy=0, in_ready=0; outputs hold; start -> RUN with accumulators cleared in the same edge.
REQ-026 start while in RUN or DRAIN is ignored.
REQ-027 in_valid low in RUN stalls: no accumulator or counter change.
REQ-028 Accumulators saturate: no wrap; sum_abs_err width covers 4096*127 worst case without overflow.
REQ-029 Inputs are ignored whenever in_ready=0.

Reset
REQ-030 rst_n low asynchronously forces IDLE; err_count, max_abs_err, sum_abs_err, sample counter, pipeline valid = 0; in_ready=0, busy=0, done=0.
REQ-031 Reset asserted mid-run discards the partial run; no done pulse is produced.
REQ-032 Release of rst_n leaves the block in IDLE until start.

Structure
REQ-033 Shared package holds the FSM state enum, OP_W default, accumulator widths (13, 19) and NUM_SAMPLES maximum.
REQ-034 One sub-module, adder_abs_err: combinational exact sum and absolute difference of in_approx; the parent holds FSM, counter, pipeline and accumulators.

Verification
REQ-035 Exhaustive sweep a,b in 0..63 with exact approx -> err_count=0, max_abs_err=0, sum_abs_err=0, done 2 cycles after last accept.
REQ-036 Same sweep, approx = exact with bit0 forced 0 -> err_count=2048, max_abs_err=1, sum_abs_err=2048.
REQ-037 Same sweep, approx=0 -> err_count=4095, max_abs_err=126, sum_abs_err=258048.
REQ-038 Random in_valid gaps (50% duty) with approx=0 -> identical results to REQ-037; no sample counted twice.
REQ-039 rst_n low after 1000 accepts -> all outputs 0 at once, IDLE; next start and full sweep gives REQ-035 results.
REQ-040 start pulsed during RUN and in DONE -> ignored in RUN; in DONE restarts with cleared accumulators.

Source files
------------

// File: rtl/adder_err_accum_pkg.sv
// Shared types and widths for the approximate-adder error accumulator.
package adder_err_accum_pkg;

  localparam int unsigned OpWDefault = 6;
  localparam int unsigned MaxSamples = 4096;
  localparam int unsigned ErrCntW    = 13;
  localparam int unsigned SumErrW    = 19;
  localparam int unsigned CntW       = $clog2(MaxSamples + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/adder_err_accum_if.sv
// Sample handshake, run control and result bundle of the error accumulator.
interface adder_err_accum_if
  import adder_err_accum_pkg::*;
#(
  parameter int unsigned OP_W = OpWDefault
);

  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_a;
  logic [OP_W-1:0]     in_b;
  logic [OP_W:0]       in_approx;
  logic                busy;
  logic                done;
  logic [ErrCntW-1:0]  err_count;
  logic [OP_W:0]       max_abs_err;
  logic [SumErrW-1:0]  sum_abs_err;

  modport master (
    output start, in_valid, in_a, in_b, in_approx,
    input  in_ready, busy, done, err_count, max_abs_err, sum_abs_err
  );

  modport slave (
    input  start, in_valid, in_a, in_b, in_approx,
    output in_ready, busy, done, err_count, max_abs_err, sum_abs_err
  );

endinterface

// File: rtl/adder_abs_err.sv
// Combinational exact sum of two operands and |approx - exact| of the adder under test.
module adder_abs_err
  import adder_err_accum_pkg::*;
#(
  parameter int unsigned OP_W = OpWDefault
) (
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  logic [OP_W:0]   approx_i,
  output logic [OP_W:0]   abs_err_o
);

  logic [OP_W:0]   exact;
  logic [OP_W+1:0] diff;
  logic [OP_W+1:0] neg_diff;

  always_comb begin
    exact    = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, approx_i} - {1'b0, exact};
    neg_diff = '0 - diff;
    // Both operands are below 2^(OP_W+1), so the magnitude always fits OP_W+1 bits.
    abs_err_o = diff[OP_W+1] ? neg_diff[OP_W:0] : diff[OP_W:0];
  end

endmodule

// File: rtl/adder_err_accum.sv
// Run controller: accepts NUM_SAMPLES samples, registers each error once and accumulates
// error count, maximum and sum with saturation.
module adder_err_accum
  import adder_err_accum_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = MaxSamples,
  parameter int unsigned OP_W        = OpWDefault
) (
  input logic              clk,
  input logic              rst_n,
  adder_err_accum_if.slave bus
);

  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_SAMPLES - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pipe_vld_q, pipe_vld_d;
  logic [OP_W:0]       pipe_abs_q, pipe_abs_d;
  logic [ErrCntW-1:0]  err_q, err_d;
  logic [OP_W:0]       max_q, max_d;
  logic [SumErrW-1:0]  sum_q, sum_d;
  logic [SumErrW:0]    sum_ext;
  logic [OP_W:0]       abs_err;
  logic                accept;
  logic                clear;

  adder_abs_err #(
    .OP_W(OP_W)
  ) u_abs_err (
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .approx_i (bus.in_approx),
    .abs_err_o(abs_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          clear   = 1'b1;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_vld_d = accept;
    pipe_abs_d = accept ? abs_err : pipe_abs_q;
    err_d      = err_q;
    max_d      = max_q;
    sum_d      = sum_q;
    sum_ext    = {1'b0, sum_q} + (SumErrW + 1)'(pipe_abs_q);
    if (clear) begin
      pipe_vld_d = 1'b0;
      err_d      = '0;
      max_d      = '0;
      sum_d      = '0;
    end else if (pipe_vld_q) begin
      if ((pipe_abs_q != '0) && (err_q != '1)) err_d = err_q + ErrCntW'(1);
      if (pipe_abs_q > max_q) max_d = pipe_abs_q;
      sum_d = sum_ext[SumErrW] ? '1 : sum_ext[SumErrW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_abs_q <= '0;
      err_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_abs_q <= pipe_abs_d;
      err_q      <= err_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.in_ready    = (state_q == StRun);
  assign bus.busy        = (state_q == StRun) || (state_q == StDrain);
  assign bus.done        = (state_q == StDone);
  assign bus.err_count   = err_q;
  assign bus.max_abs_err = max_q;
  assign bus.sum_abs_err = sum_q;

endmodule

// File: tb/tb_adder_err_accum.sv
// Randomized self-checking bench for adder_err_accum against a run-level reference model.
module tb_adder_err_accum;
  import adder_err_accum_pkg::*;

  localparam int unsigned OpW = 6;
  localparam int unsigned N   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  adder_err_accum_if #(.OP_W(OpW)) bus ();

  adder_err_accum #(
    .NUM_SAMPLES(N),
    .OP_W       (OpW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int abs_err(input int a, input int b, input int ap);
    int d;
    d = ap - (a + b);
    return (d < 0) ? -d : d;
  endfunction

  // Reference model: values here describe the DUT after the next rising edge.
  typedef enum int {MIdle, MRun, MDrain, MDone} mphase_e;
  mphase_e m_phase    = MIdle;
  int      m_cnt      = 0;
  longint  m_err      = 0;
  longint  m_max      = 0;
  longint  m_sum      = 0;
  bit      m_pend     = 1'b0;
  int      m_pend_abs = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = MIdle;
      m_cnt   = 0;
      m_err   = 0;
      m_max   = 0;
      m_sum   = 0;
      m_pend  = 1'b0;
    end
    check("in_ready", bus.in_ready, m_phase == MRun);
    check("busy", bus.busy, (m_phase == MRun) || (m_phase == MDrain));
    check("done", bus.done, m_phase == MDone);
    check("err_count", bus.err_count, m_err);
    check("max_abs_err", bus.max_abs_err, m_max);
    check("sum_abs_err", bus.sum_abs_err, m_sum);
    if (rst_n) begin
      if (m_pend) begin
        if (m_pend_abs != 0 && m_err < 8191) m_err++;
        if (m_pend_abs > m_max) m_max = m_pend_abs;
        m_sum = m_sum + m_pend_abs;
        if (m_sum > 524287) m_sum = 524287;
      end
      m_pend = 1'b0;
      case (m_phase)
        MIdle, MDone: begin
          if (bus.start) begin
            m_phase = MRun;
            m_cnt   = 0;
            m_err   = 0;
            m_max   = 0;
            m_sum   = 0;
          end
        end
        MRun: begin
          if (bus.in_valid) begin
            m_pend     = 1'b1;
            m_pend_abs = abs_err(int'(bus.in_a), int'(bus.in_b), int'(bus.in_approx));
            m_cnt++;
            if (m_cnt == N) m_phase = MDrain;
          end
        end
        default: m_phase = MDone;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OpW:0] approx_of(input int mode, input int a, input int b);
    logic [OpW:0] s;
    s = (OpW + 1)'(a + b);
    case (mode)
      0:       return s;
      1:       return {s[OpW:1], 1'b0};
      2:       return '0;
      default: return (OpW + 1)'($urandom_range(127, 0));
    endcase
  endfunction

  // Full a,b sweep; stop_after >= 0 returns early with that many samples delivered.
  task automatic run_sweep(input int mode, input bit gaps, input int stop_after,
                           input string tag);
    int a, b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_start_busy"}, bus.busy, 1);
    check({tag, "_start_err_clr"}, bus.err_count, 0);
    check({tag, "_start_sum_clr"}, bus.sum_abs_err, 0);
    for (int i = 0; i < int'(N); i++) begin
      if (i == stop_after) return;
      if (gaps) begin
        for (int g = 0; g < 8; g++) begin
          if ($urandom_range(1, 0) == 0) break;
          bus.in_valid  = 1'b0;
          bus.in_a      = OpW'($urandom);
          bus.in_b      = OpW'($urandom);
          bus.start     = ($urandom_range(7, 0) == 0);
          tick();
          bus.start     = 1'b0;
        end
      end
      a = (i >> 6) & 63;
      b = i & 63;
      bus.in_a      = OpW'(a);
      bus.in_b      = OpW'(b);
      bus.in_approx = approx_of(mode, a, b);
      bus.in_valid  = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check({tag, "_drain_done"}, bus.done, 0);
    check({tag, "_drain_busy"}, bus.busy, 1);
    tick();
    check({tag, "_done_level"}, bus.done, 1);
    check({tag, "_done_busy"}, bus.busy, 0);
  endtask

  task automatic expect_results(input string tag, input longint e, input longint m,
                                input longint s);
    check({tag, "_err_count"}, bus.err_count, e);
    check({tag, "_max_abs_err"}, bus.max_abs_err, m);
    check({tag, "_sum_abs_err"}, bus.sum_abs_err, s);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    expect_results("rst", 0, 0, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_release", bus.busy, 0);

    run_sweep(0, 1'b0, -1, "exact");
    expect_results("exact", 0, 0, 0);

    // Garbage offered while DONE must be ignored.
    bus.in_valid  = 1'b1;
    bus.in_approx = 7'h55;
    repeat (4) tick();
    bus.in_valid = 1'b0;
    expect_results("done_hold", 0, 0, 0);

    run_sweep(1, 1'b0, -1, "bit0");
    expect_results("bit0", 2048, 1, 2048);

    run_sweep(2, 1'b0, -1, "zero");
    expect_results("zero", 4095, 126, 258048);

    run_sweep(2, 1'b1, -1, "gaps");
    expect_results("gaps", 4095, 126, 258048);

    run_sweep(3, 1'b1, -1, "rand");

    run_sweep(2, 1'b0, 1000, "midrst");
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_ready", bus.in_ready, 0);
    check("midrst_done", bus.done, 0);
    expect_results("midrst", 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("midrst_idle_busy", bus.busy, 0);
    check("midrst_idle_done", bus.done, 0);

    run_sweep(0, 1'b0, -1, "after_rst");
    expect_results("after_rst", 0, 0, 0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
